// File: rtl/pool_out_buffer.sv
// pool_out_buffer: FIFO between the pooling stage and the feature-map writer.
// Each accepted pooled value is tagged with its (row, col) position in the
// O x O pooled map (O = M/P) and a last-element flag. A registered stall
// request lets the controller gate the pooler before the FIFO overflows.
// Optional feature macro: POOL_OUT_BUF_RELU_EN (negative inputs stored as 0).
module pool_out_buffer #(
  parameter int M            = 4,
  parameter int P            = 2,
  parameter int dataWidth    = 16,
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 2,
  localparam int O  = M / P,
  localparam int TW = (O > 1) ? $clog2(O) : 1
) (
  input  logic                 clk,
  input  logic                 master_rst,
  input  logic [dataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 stall,
  output logic [dataWidth-1:0] m_data,
  output logic [TW-1:0]        m_row,
  output logic [TW-1:0]        m_col,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = dataWidth + 2 * TW + 1;

  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic [CW-1:0]        free_next;
  logic [TW-1:0]        wr_row;
  logic [TW-1:0]        wr_col;
  logic                 wr_last;
  logic                 full;
  logic                 wr_en;
  logic                 rd_en;
  logic [dataWidth-1:0] wr_data;
  logic [EW-1:0]        head;
  logic                 stall_q;
  logic                 frame_done_q;
  logic                 overflow_q;

  // Handshake decode: a full FIFO still accepts a write when the head pops
  // in the same cycle, so the slot freed by the read is reused at once.
  always_comb begin
    full    = (count == CW'(DEPTH));
    rd_en   = (count != '0) && m_ready;
    wr_en   = in_valid && (!full || rd_en);
    wr_last = (wr_row == TW'(O - 1)) && (wr_col == TW'(O - 1));
`ifdef POOL_OUT_BUF_RELU_EN
    wr_data = in_data[dataWidth-1] ? '0 : in_data;
`else
    wr_data = in_data;
`endif
    count_next = count;
    if (wr_en && !rd_en) begin
      count_next = count + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_next = count - CW'(1);
    end
    free_next = CW'(DEPTH) - count_next;
  end

  // Storage array holds no control state, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {wr_data, wr_row, wr_col, wr_last};
    end
  end

  // Pointers, occupancy and the row/col tag counters of the write side.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_row <= '0;
      wr_col <= '0;
    end else begin
      count <= count_next;
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (wr_col == TW'(O - 1)) begin
          wr_col <= '0;
          wr_row <= wr_last ? '0 : wr_row + TW'(1);
        end else begin
          wr_col <= wr_col + TW'(1);
        end
      end
    end
  end

  // Status flags: stall tracks post-edge occupancy, frame_done pulses after
  // the last element leaves, overflow latches any dropped input.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      stall_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      stall_q      <= (free_next <= CW'(STALL_MARGIN));
      frame_done_q <= rd_en && head[0];
      if (in_valid && full && !rd_en) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Head entry is only presented while the FIFO holds data; zero otherwise.
  always_comb begin
    m_valid    = (count != '0);
    head       = m_valid ? mem[rd_ptr] : '0;
    m_data     = head[EW-1 -: dataWidth];
    m_row      = head[2*TW:TW+1];
    m_col      = head[TW:1];
    m_last     = head[0];
    stall      = stall_q;
    frame_done = frame_done_q;
    overflow   = overflow_q;
  end

endmodule
